// File: rtl/xy_switch_np_if.sv
// Device-side buses of xy_switch_np: NP X ports and NP Y ports, each with tx and rx handshakes.
// X_cnt_o / Y_cnt_o exist only when SWITCH_STATS_EN is defined.
interface xy_switch_np_if #(
    parameter int DW = 4,
    parameter int NP = 4
);
    localparam int AW = $clog2(NP);

    logic [NP*DW-1:0] X_dat_i;
    logic [NP*AW-1:0] X_adr_i;
    logic [NP-1:0]    X_validtx;
    logic [NP-1:0]    X_acktx;
    logic [NP*DW-1:0] X_dat_o;
    logic [NP-1:0]    X_validrx;
    logic [NP-1:0]    X_ackrx;

    logic [NP*DW-1:0] Y_dat_i;
    logic [NP*AW-1:0] Y_adr_i;
    logic [NP-1:0]    Y_validtx;
    logic [NP-1:0]    Y_acktx;
    logic [NP*DW-1:0] Y_dat_o;
    logic [NP-1:0]    Y_validrx;
    logic [NP-1:0]    Y_ackrx;

`ifdef SWITCH_STATS_EN
    logic [15:0]      X_cnt_o;
    logic [15:0]      Y_cnt_o;

    modport slave (
        input  X_dat_i, X_adr_i, X_validtx, X_ackrx,
        input  Y_dat_i, Y_adr_i, Y_validtx, Y_ackrx,
        output X_acktx, X_dat_o, X_validrx,
        output Y_acktx, Y_dat_o, Y_validrx,
        output X_cnt_o, Y_cnt_o
    );

    modport master (
        output X_dat_i, X_adr_i, X_validtx, X_ackrx,
        output Y_dat_i, Y_adr_i, Y_validtx, Y_ackrx,
        input  X_acktx, X_dat_o, X_validrx,
        input  Y_acktx, Y_dat_o, Y_validrx,
        input  X_cnt_o, Y_cnt_o
    );
`else
    modport slave (
        input  X_dat_i, X_adr_i, X_validtx, X_ackrx,
        input  Y_dat_i, Y_adr_i, Y_validtx, Y_ackrx,
        output X_acktx, X_dat_o, X_validrx,
        output Y_acktx, Y_dat_o, Y_validrx
    );

    modport master (
        output X_dat_i, X_adr_i, X_validtx, X_ackrx,
        output Y_dat_i, Y_adr_i, Y_validtx, Y_ackrx,
        input  X_acktx, X_dat_o, X_validrx,
        input  Y_acktx, Y_dat_o, Y_validrx
    );
`endif
endinterface

// File: rtl/xy_switch_np.sv
// NP x NP X/Y crossbar: DEPTH-word FIFO per input, round-robin arbiter plus output register per output.
// Define SWITCH_STATS_EN to add saturating per-side delivery counters (X_cnt_o / Y_cnt_o).
module xy_switch_np #(
    parameter int DW    = 4,
    parameter int DEPTH = 2,
    parameter int NP    = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    xy_switch_np_if.slave bus
);
    localparam int AW = $clog2(NP);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = AW + DW;

    // Side 0: X inputs feed Y outputs. Side 1: Y inputs feed X outputs.
    logic [DW-1:0] in_dat     [2][NP];
    logic [AW-1:0] in_adr     [2][NP];
    logic          in_valid   [2][NP];
    logic          in_ack     [2][NP];
    logic          head_valid [2][NP];
    logic [AW-1:0] head_adr   [2][NP];
    logic [DW-1:0] head_dat   [2][NP];
    logic [NP-1:0] grant      [2][NP];
    logic          out_ackrx  [2][NP];
    logic          out_valid  [2][NP];
    logic [DW-1:0] out_dat    [2][NP];

    genvar gs, gi;

    generate
        for (gi = 0; gi < NP; gi++) begin : g_map
            assign in_dat[0][gi]   = bus.X_dat_i[gi*DW +: DW];
            assign in_adr[0][gi]   = bus.X_adr_i[gi*AW +: AW];
            assign in_valid[0][gi] = bus.X_validtx[gi];
            assign in_dat[1][gi]   = bus.Y_dat_i[gi*DW +: DW];
            assign in_adr[1][gi]   = bus.Y_adr_i[gi*AW +: AW];
            assign in_valid[1][gi] = bus.Y_validtx[gi];

            assign bus.X_acktx[gi] = in_ack[0][gi];
            assign bus.Y_acktx[gi] = in_ack[1][gi];

            assign out_ackrx[0][gi]          = bus.Y_ackrx[gi];
            assign out_ackrx[1][gi]          = bus.X_ackrx[gi];
            assign bus.Y_validrx[gi]         = out_valid[0][gi];
            assign bus.Y_dat_o[gi*DW +: DW]  = out_dat[0][gi];
            assign bus.X_validrx[gi]         = out_valid[1][gi];
            assign bus.X_dat_o[gi*DW +: DW]  = out_dat[1][gi];
        end

        for (gs = 0; gs < 2; gs++) begin : g_side
            for (gi = 0; gi < NP; gi++) begin : g_fifo
                logic [EW-1:0] mem [DEPTH];
                logic [PW-1:0] wr_ptr_reg;
                logic [PW-1:0] rd_ptr_reg;
                logic [CW-1:0] count_reg;
                logic          full;
                logic          push;
                logic          pop;

                function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
                    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
                endfunction

                // Held low during reset so nothing is accepted until the switch is live.
                assign full           = (count_reg == CW'(DEPTH));
                assign in_ack[gs][gi] = rst_ni & ~full;
                assign push           = in_valid[gs][gi] & in_ack[gs][gi];

                always_comb begin
                    pop = 1'b0;
                    for (int o = 0; o < NP; o++) begin
                        pop = pop | grant[gs][o][gi];
                    end
                end

                assign head_valid[gs][gi] = (count_reg != '0);
                assign head_adr[gs][gi]   = mem[rd_ptr_reg][EW-1:DW];
                assign head_dat[gs][gi]   = mem[rd_ptr_reg][DW-1:0];

                always_ff @(posedge clk_i) begin
                    if (push) begin
                        mem[wr_ptr_reg] <= {in_adr[gs][gi], in_dat[gs][gi]};
                    end
                end

                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        wr_ptr_reg <= '0;
                        rd_ptr_reg <= '0;
                        count_reg  <= '0;
                    end else begin
                        if (push) begin
                            wr_ptr_reg <= wrap_inc(wr_ptr_reg);
                        end
                        if (pop) begin
                            rd_ptr_reg <= wrap_inc(rd_ptr_reg);
                        end
                        case ({push, pop})
                            2'b10:   count_reg <= count_reg + CW'(1);
                            2'b01:   count_reg <= count_reg - CW'(1);
                            default: count_reg <= count_reg;
                        endcase
                    end
                end
            end

            for (gi = 0; gi < NP; gi++) begin : g_out
                logic [NP-1:0] req;
                logic [NP-1:0] gnt;
                logic [AW-1:0] ptr_reg;
                logic [AW-1:0] sel;
                logic [AW-1:0] idx;
                logic          load;
                logic          any;
                logic          valid_reg;
                logic [DW-1:0] dat_reg;

                assign load = ~valid_reg | out_ackrx[gs][gi];

                always_comb begin
                    req = '0;
                    for (int i = 0; i < NP; i++) begin
                        req[i] = head_valid[gs][i] & (head_adr[gs][i] == AW'(gi));
                    end
                end

                // Search starts one past the last winner, wrapping mod NP via AW-bit overflow.
                always_comb begin
                    gnt = '0;
                    sel = ptr_reg;
                    idx = ptr_reg;
                    any = 1'b0;
                    for (int k = 1; k <= NP; k++) begin
                        idx = ptr_reg + AW'(k);
                        if (!any && req[idx]) begin
                            any = 1'b1;
                            sel = idx;
                        end
                    end
                    if (load && any) begin
                        gnt[sel] = 1'b1;
                    end
                end

                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        valid_reg <= 1'b0;
                        dat_reg   <= '0;
                        ptr_reg   <= AW'(NP - 1);
                    end else if (load) begin
                        valid_reg <= any;
                        if (any) begin
                            dat_reg <= head_dat[gs][sel];
                            ptr_reg <= sel;
                        end
                    end
                end

                assign grant[gs][gi]     = gnt;
                assign out_valid[gs][gi] = valid_reg;
                assign out_dat[gs][gi]   = dat_reg;
            end
        end

`ifdef SWITCH_STATS_EN
        for (gs = 0; gs < 2; gs++) begin : g_stats
            logic [AW:0]   n_done;
            logic [16:0]   sum;
            logic [15:0]   cnt_reg;

            // Several outputs may complete in one cycle; add them all, then clamp.
            always_comb begin
                n_done = '0;
                for (int i = 0; i < NP; i++) begin
                    n_done = n_done + (AW+1)'(out_valid[gs][i] & out_ackrx[gs][i]);
                end
                sum = {1'b0, cnt_reg} + 17'(n_done);
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= sum[16] ? 16'hFFFF : sum[15:0];
                end
            end

            if (gs == 0) begin : g_y
                assign bus.Y_cnt_o = cnt_reg;
            end else begin : g_x
                assign bus.X_cnt_o = cnt_reg;
            end
        end
`endif
    endgenerate
endmodule

// File: tb/tb_xy_switch_np.sv
// Directed and randomised bench for xy_switch_np, checked every cycle against a queue-based model.
// Define SWITCH_STATS_EN for both bench and RTL to also cover the delivery counters.
module tb_xy_switch_np;
    localparam int DW    = 4;
    localparam int DEPTH = 2;
    localparam int NP    = 4;
    localparam int AW    = $clog2(NP);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xy_switch_np_if #(.DW(DW), .NP(NP)) bus ();

    xy_switch_np #(.DW(DW), .DEPTH(DEPTH), .NP(NP)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: per-input word queues, per-output word/valid/last-winner, delivery counts.
    // Index 0 = X inputs and the Y outputs they feed; index 1 = Y inputs and X outputs.
    logic [AW+DW-1:0] mq [2][NP][$];
    logic             mv [2][NP];
    logic [DW-1:0]    md [2][NP];
    int               mp [2][NP];
    int               mcnt [2];

    always @(posedge clk or negedge rst_n) begin : model
        logic [NP-1:0]    vt, ak, popf, fullp;
        logic [NP*AW-1:0] va;
        logic [NP*DW-1:0] vd;
        logic [AW+DW-1:0] e;
        int               win, ii;
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                mcnt[s] = 0;
                for (int i = 0; i < NP; i++) begin
                    mq[s][i].delete();
                    mv[s][i] = 1'b0;
                    md[s][i] = '0;
                    mp[s][i] = NP - 1;
                end
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                vt = (s == 0) ? bus.X_validtx : bus.Y_validtx;
                va = (s == 0) ? bus.X_adr_i   : bus.Y_adr_i;
                vd = (s == 0) ? bus.X_dat_i   : bus.Y_dat_i;
                ak = (s == 0) ? bus.Y_ackrx   : bus.X_ackrx;
                popf = '0;
                for (int i = 0; i < NP; i++) fullp[i] = (mq[s][i].size() >= DEPTH);
                for (int o = 0; o < NP; o++) begin
                    if (mv[s][o] && ak[o] && mcnt[s] < 65535) mcnt[s]++;
                    if (!mv[s][o] || ak[o]) begin
                        win = -1;
                        for (int k = 1; k <= NP; k++) begin
                            ii = (mp[s][o] + k) % NP;
                            if (win < 0 && mq[s][ii].size() > 0) begin
                                e = mq[s][ii][0];
                                if (int'(e[AW+DW-1:DW]) == o) win = ii;
                            end
                        end
                        if (win >= 0) begin
                            e = mq[s][win][0];
                            mv[s][o] = 1'b1;
                            md[s][o] = e[DW-1:0];
                            mp[s][o] = win;
                            popf[win] = 1'b1;
                        end else begin
                            mv[s][o] = 1'b0;
                        end
                    end
                end
                for (int i = 0; i < NP; i++) if (popf[i]) void'(mq[s][i].pop_front());
                for (int i = 0; i < NP; i++)
                    if (vt[i] && !fullp[i]) mq[s][i].push_back({va[i*AW +: AW], vd[i*DW +: DW]});
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [NP-1:0]    ea, ev, aa, av;
        logic [NP*DW-1:0] ad;
        if (chk_en) begin
            for (int s = 0; s < 2; s++) begin
                aa = (s == 0) ? bus.X_acktx   : bus.Y_acktx;
                av = (s == 0) ? bus.Y_validrx : bus.X_validrx;
                ad = (s == 0) ? bus.Y_dat_o   : bus.X_dat_o;
                for (int i = 0; i < NP; i++) begin
                    ea[i] = rst_n && (mq[s][i].size() < DEPTH);
                    ev[i] = mv[s][i];
                end
                chk((s == 0) ? "X_acktx" : "Y_acktx", aa, ea);
                chk((s == 0) ? "Y_validrx" : "X_validrx", av, ev);
                for (int o = 0; o < NP; o++)
                    if (mv[s][o]) chk((s == 0) ? "Y_dat_o" : "X_dat_o", ad[o*DW +: DW], md[s][o]);
            end
`ifdef SWITCH_STATS_EN
            chk("Y_cnt_o", bus.Y_cnt_o, mcnt[0]);
            chk("X_cnt_o", bus.X_cnt_o, mcnt[1]);
`endif
        end
    end

    task automatic idle_tx();
        bus.X_validtx = '0;
        bus.Y_validtx = '0;
    endtask

    task automatic set_tx(input int s, input int p, input int a, input int d);
        if (s == 0) begin
            bus.X_validtx[p]          = 1'b1;
            bus.X_adr_i[p*AW +: AW]   = AW'(a);
            bus.X_dat_i[p*DW +: DW]   = DW'(d);
        end else begin
            bus.Y_validtx[p]          = 1'b1;
            bus.Y_adr_i[p*AW +: AW]   = AW'(a);
            bus.Y_dat_i[p*DW +: DW]   = DW'(d);
        end
    endtask

    task automatic rand_tx();
        idle_tx();
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 3) != 0) set_tx(s, p, int'($urandom_range(0, NP-1)), int'($urandom));
    endtask

    task automatic rand_ack(input int pct);
        for (int p = 0; p < NP; p++) begin
            bus.X_ackrx[p] = ($urandom_range(0, 99) < pct);
            bus.Y_ackrx[p] = ($urandom_range(0, 99) < pct);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   nw;
        logic ack;
        int   got [$];
        int   dens [6];
        dens = '{100, 70, 40, 10, 90, 50};

        bus.X_dat_i = '0; bus.X_adr_i = '0; bus.X_validtx = '0; bus.X_ackrx = '0;
        bus.Y_dat_i = '0; bus.Y_adr_i = '0; bus.Y_validtx = '0; bus.Y_ackrx = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("acktx_in_reset",   {bus.Y_acktx, bus.X_acktx}, 0);
        chk("validrx_in_reset", {bus.Y_validrx, bus.X_validrx}, 0);
        chk("dat_o_in_reset",   {bus.Y_dat_o, bus.X_dat_o}, 0);
        chk_en = 1'b1;
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("acktx_after_reset", {bus.Y_acktx, bus.X_acktx}, 8'hFF);

        // Single word X0 -> Y2
        #1;
        bus.X_ackrx = '1; bus.Y_ackrx = '1;
        set_tx(0, 0, 2, 'hA);
        @(negedge clk); #1 idle_tx();
        @(negedge clk);
        chk("single_Y_validrx", bus.Y_validrx, 4'b0100);
        chk("single_Y2_dat", bus.Y_dat_o[2*DW +: DW], 4'hA);
        chk("single_X_validrx", bus.X_validrx, 4'b0000);
        @(negedge clk);
        chk("single_drop", bus.Y_validrx, 4'b0000);

        // Contention X0, X1, X3 -> Y1
        #1;
        set_tx(0, 0, 1, 1); set_tx(0, 1, 1, 2); set_tx(0, 3, 1, 3);
        @(negedge clk); #1 idle_tx();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("contend_valid", bus.Y_validrx[1], 1'b1);
            chk("contend_order", bus.Y_dat_o[DW +: DW], (k == 2) ? 3 : k + 1);
        end
        @(negedge clk);
        chk("contend_drain", bus.Y_validrx, 4'b0000);

        // Backpressure: X2 sends 4 words to stalled Y3
        #1;
        bus.Y_ackrx[3] = 1'b0;
        nw = 0;
        for (int c = 0; c < 8; c++) begin
            idle_tx();
            if (nw < 4) set_tx(0, 2, 3, nw + 1);
            ack = bus.X_acktx[2];
            @(negedge clk);
            if (ack && nw < 4) nw++;
            #1;
        end
        chk("bp_accepted", nw, 3);
        chk("bp_acktx_low", bus.X_acktx[2], 1'b0);
        chk("bp_held_valid", bus.Y_validrx[3], 1'b1);
        chk("bp_held_dat", bus.Y_dat_o[3*DW +: DW], 1);
        got.push_back(int'(bus.Y_dat_o[3*DW +: DW]));
        bus.Y_ackrx[3] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            idle_tx();
            if (nw < 4) set_tx(0, 2, 3, nw + 1);
            ack = bus.X_acktx[2];
            @(negedge clk);
            if (ack && nw < 4) nw++;
            if (bus.Y_validrx[3]) got.push_back(int'(bus.Y_dat_o[3*DW +: DW]));
            #1;
        end
        chk("bp_count", got.size(), 4);
        for (int k = 0; k < got.size() && k < 4; k++) chk("bp_order", got[k], k + 1);

        // Bidirectional X1 -> Y0 and Y1 -> X0
        idle_tx();
        set_tx(0, 1, 0, 5); set_tx(1, 1, 0, 6);
        @(negedge clk); #1 idle_tx();
        @(negedge clk);
        chk("bidir_Y_validrx", bus.Y_validrx, 4'b0001);
        chk("bidir_Y0_dat", bus.Y_dat_o[0 +: DW], 5);
        chk("bidir_X_validrx", bus.X_validrx, 4'b0001);
        chk("bidir_X0_dat", bus.X_dat_o[0 +: DW], 6);

        // Reset mid-operation
        #1;
        bus.X_ackrx = '0; bus.Y_ackrx = '0;
        repeat (6) begin rand_tx(); @(negedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_validrx", {bus.Y_validrx, bus.X_validrx}, 0);
        chk("rst_async_acktx",   {bus.Y_acktx, bus.X_acktx}, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        idle_tx();
        bus.X_ackrx = '1; bus.Y_ackrx = '1;
        repeat (5) begin
            @(negedge clk);
            chk("rst_no_stale", {bus.Y_validrx, bus.X_validrx}, 0);
            chk("rst_acktx_all", {bus.Y_acktx, bus.X_acktx}, 8'hFF);
        end

`ifdef SWITCH_STATS_EN
        // Five Y-side deliveries after a fresh reset
        #1;
        for (int k = 0; k < 5; k++) begin
            idle_tx(); set_tx(0, 0, 0, k);
            @(negedge clk); #1;
        end
        idle_tx();
        repeat (4) @(negedge clk);
        chk("stats_y5", bus.Y_cnt_o, 5);
        chk("stats_x0", bus.X_cnt_o, 0);
`endif

        // Randomised traffic with varying output back-pressure
        #1;
        for (int w = 0; w < 6; w++) begin
            repeat (500) begin
                rand_tx();
                rand_ack(dens[w]);
                @(negedge clk); #1;
            end
        end

`ifdef SWITCH_STATS_EN
        // Saturation: keep every port busy until both counters pin at FFFF
        bus.X_ackrx = '1; bus.Y_ackrx = '1;
        for (int t = 0; t < 40000 && !(bus.Y_cnt_o == 16'hFFFF && bus.X_cnt_o == 16'hFFFF); t++) begin
            for (int i = 0; i < NP; i++) begin
                set_tx(0, i, (i + t) % NP, t);
                set_tx(1, i, (i + t) % NP, t);
            end
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk);
        chk("stats_y_sat", bus.Y_cnt_o, 16'hFFFF);
        chk("stats_x_sat", bus.X_cnt_o, 16'hFFFF);
        #1;
`endif

        idle_tx();
        bus.X_ackrx = '1; bus.Y_ackrx = '1;
        repeat (10) @(negedge clk);
        chk("final_idle", {bus.Y_validrx, bus.X_validrx}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
